// File: rtl/m_7seg_scan_ctrl_if.sv
// Host-side bus of the 7-segment scan controller: display word in, pin-level strobes out.
// The controller itself takes the slave modport; host logic or a bench takes master.
interface m_7seg_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  w_en;
   logic                  w_ld;
   logic [4*DIGITS-1:0]   w_data;
   logic [DIGITS-1:0]     w_dp;
   logic [DIGITS-1:0]     r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic                  r_pend;
   logic                  r_frame;

   modport master (
      output w_en, w_ld, w_data, w_dp,
      input  r_an, r_seg, r_dp, r_pend, r_frame
   );

   modport slave (
      input  w_en, w_ld, w_data, w_dp,
      output r_an, r_seg, r_dp, r_pend, r_frame
   );
endinterface

// File: rtl/m_7seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with blanking gaps,
// leading-zero suppression and a shadow register committed only at frame start.
module m_7seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1000,
   parameter int BLANK  = 8,
   parameter int LZS    = 1
) (
   input  logic               w_clk,
   input  logic               w_rst_n,
   m_7seg_scan_ctrl_if.slave  bus
);

   localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e              r_state;
   logic [IW-1:0]       r_idx;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_shData;
   logic [DIGITS-1:0]   r_shDp;
   logic [4*DIGITS-1:0] r_dData;
   logic [DIGITS-1:0]   r_dDp;

   state_e              w_stateNext;
   logic [IW-1:0]       w_idxNext;
   logic [IW-1:0]       w_idxInc;
   logic                w_idxWrap;
   logic [CW-1:0]       w_cntNext;
   logic                w_commit;
   logic [4*DIGITS-1:0] w_dataNext;
   logic [DIGITS-1:0]   w_dpNext;
   logic [DIGITS-1:0]   w_lead;
   logic                w_zeroRun;
   logic [DIGITS-1:0]   w_anNext;
   logic [6:0]          w_segNext;
   logic                w_dpOutNext;

   function automatic logic [6:0] segOf(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1011000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   assign w_idxWrap = (r_idx == IW'(DIGITS - 1));
   assign w_idxInc  = w_idxWrap ? '0 : r_idx + IW'(1);

   // Scan sequencing; a commit happens on every edge that lands in SHOW of digit 0.
   always_comb begin
      w_stateNext = r_state;
      w_idxNext   = r_idx;
      w_cntNext   = r_cnt;
      w_commit    = 1'b0;
      if (!bus.w_en) begin
         w_stateNext = IDLE;
         w_idxNext   = '0;
         w_cntNext   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_stateNext = SHOW;
               w_idxNext   = '0;
               w_cntNext   = '0;
               w_commit    = 1'b1;
            end
            SHOW: begin
               if (r_cnt == CW'(DWELL - 1)) begin
                  w_cntNext = '0;
                  if (BLANK == 0) begin
                     w_idxNext = w_idxInc;
                     w_commit  = w_idxWrap;
                  end else begin
                     w_stateNext = GAP;
                  end
               end else begin
                  w_cntNext = r_cnt + CW'(1);
               end
            end
            GAP: begin
               if (r_cnt == CW'(BLANK - 1)) begin
                  w_stateNext = SHOW;
                  w_idxNext   = w_idxInc;
                  w_cntNext   = '0;
                  w_commit    = w_idxWrap;
               end else begin
                  w_cntNext = r_cnt + CW'(1);
               end
            end
            default: begin
               w_stateNext = IDLE;
               w_idxNext   = '0;
               w_cntNext   = '0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state so the registered pins match the state they belong to.
   always_comb begin
      w_dataNext  = (w_commit && bus.r_pend) ? r_shData : r_dData;
      w_dpNext    = (w_commit && bus.r_pend) ? r_shDp   : r_dDp;
      w_zeroRun   = 1'b1;
      w_lead      = '0;
      w_anNext    = '1;
      w_segNext   = 7'b1111111;
      w_dpOutNext = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zeroRun = w_zeroRun && (w_dataNext[4*i +: 4] == 4'h0);
         w_lead[i] = w_zeroRun;
      end
      if (w_stateNext == SHOW) begin
         w_anNext[w_idxNext] = 1'b0;
         w_dpOutNext         = ~w_dpNext[w_idxNext];
         if ((LZS != 0) && w_lead[w_idxNext]) begin
            w_segNext = 7'b1111111;
         end else begin
            w_segNext = segOf(w_dataNext[{w_idxNext, 2'b00} +: 4]);
         end
      end
   end

   // A load on the commit edge wins for r_pend: the older shadow goes to display, the new one waits.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_shData    <= '0;
         r_shDp      <= '0;
         r_dData     <= '0;
         r_dDp       <= '0;
         bus.r_an    <= '1;
         bus.r_seg   <= 7'b1111111;
         bus.r_dp    <= 1'b1;
         bus.r_pend  <= 1'b0;
         bus.r_frame <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_idx       <= w_idxNext;
         r_cnt       <= w_cntNext;
         r_dData     <= w_dataNext;
         r_dDp       <= w_dpNext;
         if (bus.w_ld) begin
            r_shData <= bus.w_data;
            r_shDp   <= bus.w_dp;
         end
         if (bus.w_ld) begin
            bus.r_pend <= 1'b1;
         end else if (w_commit) begin
            bus.r_pend <= 1'b0;
         end
         bus.r_an    <= w_anNext;
         bus.r_seg   <= w_segNext;
         bus.r_dp    <= w_dpOutNext;
         bus.r_frame <= w_commit;
      end
   end

endmodule

// File: tb/tb_m_7seg_scan_ctrl.sv
// Directed bench for m_7seg_scan_ctrl with DIGITS=4, DWELL=4, BLANK=2, LZS=1 (24-cycle frame).
// Every cycle of each checked frame is compared against hand-written segment patterns.
module tb_m_7seg_scan_ctrl;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_7 = 7'b1011000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;
   localparam logic [6:0] BLK   = 7'b1111111;

   localparam logic [27:0] W1234 = {SEG_1, SEG_2, SEG_3, SEG_4};
   localparam logic [27:0] W0070 = {BLK, BLK, SEG_7, SEG_0};
   localparam logic [27:0] W0000 = {BLK, BLK, BLK, SEG_0};
   localparam logic [27:0] WEF00 = {SEG_E, SEG_F, SEG_0, SEG_0};
   localparam logic [27:0] W1111 = {SEG_1, SEG_1, SEG_1, SEG_1};
   localparam logic [27:0] W5555 = {SEG_5, SEG_5, SEG_5, SEG_5};
   localparam logic [27:0] W0009 = {BLK, BLK, BLK, SEG_9};

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   m_7seg_scan_ctrl_if #(.DIGITS(4)) bus ();

   m_7seg_scan_ctrl #(
      .DIGITS (4),
      .DWELL  (4),
      .BLANK  (2),
      .LZS    (1)
   ) dut (
      .w_clk   (clk),
      .w_rst_n (rst_n),
      .bus     (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(negedge clk);
      bus.w_ld = 1'b0;
   endtask

   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp);
      bus.w_data = data;
      bus.w_dp   = dp;
      bus.w_ld   = 1'b1;
   endtask

   task automatic checkDark(input string tag, input logic expPend);
      checkOutput({tag, " an"}, 32'(bus.r_an), 32'h0000_000F);
      checkOutput({tag, " seg"}, 32'(bus.r_seg), 32'(BLK));
      checkOutput({tag, " dp"}, 32'(bus.r_dp), 32'd1);
      checkOutput({tag, " pend"}, 32'(bus.r_pend), 32'(expPend));
      checkOutput({tag, " frame"}, 32'(bus.r_frame), 32'd0);
   endtask

   // Checks cycles startK..startK+n-1 of a frame; cycle k is digit k/6, lit while k%6 < 4.
   task automatic checkCycles(input string tag, input int startK, input int n,
                              input logic [27:0] segs, input logic [3:0] dpN, input logic expPend);
      int         k;
      int         d;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic       expDp;
      string      t;
      for (int j = 0; j < n; j++) begin
         k      = startK + j;
         d      = k / 6;
         expAn  = 4'b1111;
         expSeg = BLK;
         expDp  = 1'b1;
         if ((k % 6) < 4) begin
            expAn[d] = 1'b0;
            expSeg   = segs[d*7 +: 7];
            expDp    = dpN[d];
         end
         t = $sformatf("%s k=%0d", tag, k);
         checkOutput({t, " an"}, 32'(bus.r_an), 32'(expAn));
         checkOutput({t, " seg"}, 32'(bus.r_seg), 32'(expSeg));
         checkOutput({t, " dp"}, 32'(bus.r_dp), 32'(expDp));
         checkOutput({t, " frame"}, 32'(bus.r_frame), (k == 0) ? 32'd1 : 32'd0);
         checkOutput({t, " pend"}, 32'(bus.r_pend), 32'(expPend));
         step();
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      bus.w_en   = 1'b0;
      bus.w_ld   = 1'b0;
      bus.w_data = 16'h0000;
      bus.w_dp   = 4'h0;
      rst_n      = 1'b1;
      #1 rst_n   = 1'b0;
      step();
      step();
      checkDark("reset", 1'b0);

      // Load 0x1234 while disabled, then enable and watch two frames.
      rst_n = 1'b1;
      applyStimulus(16'h1234, 4'b0000);
      step();
      checkDark("s1 loaded", 1'b1);
      bus.w_en = 1'b1;
      step();
      checkCycles("s1 f1", 0, 24, W1234, 4'b1111, 1'b0);
      checkCycles("s1 f2", 0, 24, W1234, 4'b1111, 1'b0);

      // Leading-zero suppression and decimal point.
      applyStimulus(16'h0070, 4'b0001);
      checkCycles("s2 pre", 0, 1, W1234, 4'b1111, 1'b0);
      checkCycles("s2 pre", 1, 23, W1234, 4'b1111, 1'b1);
      applyStimulus(16'h0000, 4'b0000);
      checkCycles("s2 0070", 0, 1, W0070, 4'b1110, 1'b0);
      checkCycles("s2 0070", 1, 23, W0070, 4'b1110, 1'b1);
      applyStimulus(16'h1234, 4'b0000);
      checkCycles("s2 0000", 0, 1, W0000, 4'b1111, 1'b0);
      checkCycles("s2 0000", 1, 23, W0000, 4'b1111, 1'b1);

      // Two loads during digit 2; only the last reaches the display, at the next frame.
      checkCycles("s3 run", 0, 12, W1234, 4'b1111, 1'b0);
      applyStimulus(16'hABCD, 4'b0000);
      checkCycles("s3 run", 12, 1, W1234, 4'b1111, 1'b0);
      applyStimulus(16'hEF00, 4'b0000);
      checkCycles("s3 run", 13, 11, W1234, 4'b1111, 1'b1);

      // Load 0x1111 early, then 0x5555 on the edge that commits 0x1111.
      applyStimulus(16'h1111, 4'b0000);
      checkCycles("s3 ef00", 0, 1, WEF00, 4'b1111, 1'b0);
      checkCycles("s3 ef00", 1, 22, WEF00, 4'b1111, 1'b1);
      applyStimulus(16'h5555, 4'b0000);
      checkCycles("s4 edge", 23, 1, WEF00, 4'b1111, 1'b1);
      checkCycles("s4 1111", 0, 24, W1111, 4'b1111, 1'b1);

      // Disable during digit 1, load while dark, then re-enable.
      checkCycles("s5 5555", 0, 8, W5555, 4'b1111, 1'b0);
      bus.w_en = 1'b0;
      step();
      checkDark("s5 off", 1'b0);
      applyStimulus(16'h0009, 4'b0000);
      step();
      checkDark("s5 ld", 1'b1);
      step();
      step();
      checkDark("s5 held", 1'b1);
      bus.w_en = 1'b1;
      step();
      checkCycles("s5 0009", 0, 24, W0009, 4'b1111, 1'b0);

      // Asynchronous reset between clock edges while a digit is lit.
      checkCycles("s6 pre", 0, 2, W0009, 4'b1111, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkDark("s6 async", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checkCycles("s6 after", 0, 24, W0000, 4'b1111, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
